serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_sub_cell.sv | 13 +
 rtl/serial_subtractor.sv | 109 ++++++++++
 tb/tb_serial_subtractor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter width; never below one bit so the counter stays a legal vector.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_cell.sv
// One-bit full subtractor cell: difference and borrow for a single bit position.
module sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: op_a - op_b one bit per cycle, LSB first,
// streaming each difference bit and presenting the parallel result with a handshake.
//
// Handshake: result/borrow_out are delivered when res_valid and res_ready are
// both high at a rising edge; until then res_valid, result and borrow_out hold.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             diff_bit,
    output logic             diff_bit_vld,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             borrow_out
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    // Exposed for checkers that bind to the FSM.
    state_e           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             borrow_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             cell_d;
    logic             cell_bout;
    logic             last_bit;

    sub_cell u_sub_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (bit_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a_sh         <= '0;
            b_sh         <= '0;
            borrow_q     <= 1'b0;
            bit_cnt      <= '0;
            busy         <= 1'b0;
            diff_bit     <= 1'b0;
            diff_bit_vld <= 1'b0;
            res_valid    <= 1'b0;
            result       <= '0;
            borrow_out   <= 1'b0;
        end else begin
            diff_bit_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh     <= op_a;
                        b_sh     <= op_b;
                        borrow_q <= 1'b0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff_bit     <= cell_d;
                    diff_bit_vld <= 1'b1;
                    result       <= {cell_d, result[WIDTH-1:1]};
                    borrow_q     <= cell_bout;
                    a_sh         <= a_sh >> 1;
                    b_sh         <= b_sh >> 1;
                    if (last_bit) begin
                        bit_cnt    <= '0;
                        borrow_out <= cell_bout;
                        state      <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // res_valid is raised one edge after the last bit lands, so the
                    // handshake only completes once the result has been visible.
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): hand-computed differences,
// serial bit stream, DONE hold, ignored starts and mid-run reset.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         diff_bit;
    logic         diff_bit_vld;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         borrow_out;

    int n_vec = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_a         (op_a),
        .op_b         (op_b),
        .busy         (busy),
        .diff_bit     (diff_bit),
        .diff_bit_vld (diff_bit_vld),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .result       (result),
        .borrow_out   (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},       32'(busy),         32'd0);
        check({tag, " diff_bit"},   32'(diff_bit),     32'd0);
        check({tag, " vld"},        32'(diff_bit_vld), 32'd0);
        check({tag, " res_valid"},  32'(res_valid),    32'd0);
        check({tag, " result"},     32'(result),       32'd0);
        check({tag, " borrow_out"}, 32'(borrow_out),   32'd0);
    endtask

    // Start an operation and follow it bit by bit up to res_valid; a start with
    // op_a=0x99 is injected before bit inj_bit (negative: none).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_r, input int inj_bit);
        logic [0:0] eb;
        for (int i = 0; i < W; i++) exp_q.push_back(exp_r[i]);
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        step();
        start = 1'b0;
        check("busy after start", 32'(busy), 32'd1);
        check("vld after start", 32'(diff_bit_vld), 32'd0);
        for (int i = 0; i < W; i++) begin
            if (i == inj_bit) begin
                start = 1'b1;
                op_a  = 8'h99;
            end
            step();
            start = 1'b0;
            eb = exp_q.pop_front();
            check($sformatf("bit%0d vld", i), 32'(diff_bit_vld), 32'd1);
            check($sformatf("bit%0d value", i), 32'(diff_bit), 32'(eb));
            check($sformatf("bit%0d res_valid low", i), 32'(res_valid), 32'd0);
        end
        step();
        check("res_valid at edge W+1", 32'(res_valid), 32'd1);
        check("vld after last bit", 32'(diff_bit_vld), 32'd0);
    endtask

    // Hold DONE for hold cycles (optionally poking start), then hand the result over.
    task automatic finish_op(input logic [W-1:0] exp_r, input logic exp_bo,
                             input int hold, input logic poke);
        check("result", 32'(result), 32'(exp_r));
        check("borrow_out", 32'(borrow_out), 32'(exp_bo));
        res_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (poke && k == 1) begin
                start = 1'b1;
                op_a  = 8'h99;
            end
            step();
            start = 1'b0;
            check($sformatf("hold%0d res_valid", k), 32'(res_valid), 32'd1);
            check($sformatf("hold%0d result", k), 32'(result), 32'(exp_r));
            check($sformatf("hold%0d borrow", k), 32'(borrow_out), 32'(exp_bo));
            check($sformatf("hold%0d busy", k), 32'(busy), 32'd1);
        end
        res_ready = 1'b1;
        start     = poke;
        step();
        res_ready = 1'b0;
        start     = 1'b0;
        check("handover res_valid", 32'(res_valid), 32'd0);
        check("handover busy", 32'(busy), 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("idle busy", 32'(busy), 32'd0);
        check("idle res_valid", 32'(res_valid), 32'd0);
        check("idle result hold", 32'(result), 32'(exp_r));
        check("idle borrow hold", 32'(borrow_out), 32'(exp_bo));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        op_a      = 8'h55;
        op_b      = 8'h11;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        check_reset_outputs("reset");
        step();
        check("start under reset ignored", 32'(busy), 32'd0);

        run_op(8'h35, 8'h12, 8'h23, -1);
        finish_op(8'h23, 1'b0, 1, 1'b0);

        run_op(8'h00, 8'h01, 8'hFF, -1);
        finish_op(8'hFF, 1'b1, 1, 1'b0);

        run_op(8'hFF, 8'hFF, 8'h00, -1);
        finish_op(8'h00, 1'b0, 1, 1'b0);

        run_op(8'hA5, 8'h5A, 8'h4B, -1);
        finish_op(8'h4B, 1'b0, 5, 1'b0);

        run_op(8'h7F, 8'h80, 8'hFF, -1);
        finish_op(8'hFF, 1'b1, 1, 1'b0);

        run_op(8'h80, 8'h7F, 8'h01, -1);
        finish_op(8'h01, 1'b0, 1, 1'b0);

        // Starts at bit 3, during DONE and at handover must all be dropped.
        run_op(8'h35, 8'h12, 8'h23, 3);
        finish_op(8'h23, 1'b0, 3, 1'b1);

        // Reset when bit 4 would be processed discards the operation.
        @(negedge clk);
        start = 1'b1;
        op_a  = 8'h35;
        op_b  = 8'h12;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("pre-reset bit%0d vld", i), 32'(diff_bit_vld), 32'd1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("mid-run reset");
        step();
        check("post-reset idle", 32'(busy), 32'd0);

        run_op(8'h10, 8'h20, 8'hF0, -1);
        finish_op(8'hF0, 1'b1, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
